// File: rtl/xpb_seq_accum.sv
// Sequential xpb accumulator: issues one 5-bit segment of in_hi per cycle to the xpb table bank
// and sums the returned terms onto in_lo. Optional macro XPB_ZERO_SKIP_EN skips zero-index segments.
module xpb_seq_accum #(
  parameter int NUM_SEG = 8,
  parameter int WORD_W  = 1024,
  parameter int ACC_W   = WORD_W + $clog2(NUM_SEG + 1)
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic                                                in_valid,
  output logic                                                in_ready,
  input  logic [NUM_SEG*5-1:0]                                in_hi,
  input  logic [WORD_W-1:0]                                   in_lo,
  output logic [((NUM_SEG > 1) ? $clog2(NUM_SEG) : 1)-1:0]    seg_sel,
  output logic [4:0]                                          seg_idx,
  input  logic [WORD_W-1:0]                                   xpb_in,
  output logic                                                out_valid,
  input  logic                                                out_ready,
  output logic [ACC_W-1:0]                                    out_sum
);

  localparam int SEL_W = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
  localparam int HI_W  = NUM_SEG * 5;
  localparam logic [SEL_W-1:0] LAST_K = SEL_W'(NUM_SEG - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [HI_W-1:0]  segs;
  logic [HI_W-1:0]  segs_n;
  logic [SEL_W-1:0] k;
  logic [SEL_W-1:0] k_n;
  logic [SEL_W-1:0] sel_n;
  logic [4:0]       idx_n;
  logic             accept;
  logic             pend;
  logic [ACC_W-1:0] acc;

`ifdef XPB_ZERO_SKIP_EN
  logic [SEL_W:0]   nz;

  // Lowest segment at or above 'from' holding a non-zero index, as {found, position}.
  function automatic logic [SEL_W:0] next_nz(input logic [HI_W-1:0] v, input int from);
    logic [SEL_W:0] r;
    r = '0;
    for (int j = NUM_SEG - 1; j >= 0; j--) begin
      if (j >= from && v[j*5 +: 5] != 5'd0) begin
        r = {1'b1, SEL_W'(j)};
      end
    end
    return r;
  endfunction
`endif

  // Next-state, segment pointer and next table request.
  always_comb begin
    state_n = state;
    k_n     = k;
    segs_n  = segs;
    accept  = 1'b0;
`ifdef XPB_ZERO_SKIP_EN
    nz      = '0;
`endif
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept = 1'b1;
          segs_n = in_hi;
`ifdef XPB_ZERO_SKIP_EN
          nz = next_nz(in_hi, 0);
          if (nz[SEL_W]) begin
            state_n = ISSUE;
            k_n     = nz[SEL_W-1:0];
          end else begin
            state_n = DRAIN;
            k_n     = '0;
          end
`else
          state_n = ISSUE;
          k_n     = '0;
`endif
        end else begin
          state_n = IDLE;
        end
      end
      ISSUE: begin
`ifdef XPB_ZERO_SKIP_EN
        nz = next_nz(segs, int'(k) + 1);
        if (nz[SEL_W]) begin
          k_n = nz[SEL_W-1:0];
        end else begin
          state_n = DRAIN;
          k_n     = '0;
        end
`else
        if (k == LAST_K) begin
          state_n = DRAIN;
          k_n     = '0;
        end else begin
          k_n = k + SEL_W'(1);
        end
`endif
      end
      DRAIN: state_n = DONE;
      DONE: begin
        if (out_ready) begin
          state_n = IDLE;
        end else begin
          state_n = DONE;
        end
      end
      default: begin
        state_n = IDLE;
        k_n     = '0;
      end
    endcase

    // Table reads outside ISSUE stay at index 0, which the tables define as zero.
    if (state_n == ISSUE) begin
      sel_n = k_n;
      idx_n = segs_n[int'(k_n)*5 +: 5];
    end else begin
      sel_n = '0;
      idx_n = 5'd0;
    end
  end

  // State, pointer, registered outputs and the accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      segs      <= '0;
      k         <= '0;
      pend      <= 1'b0;
      acc       <= '0;
      seg_sel   <= '0;
      seg_idx   <= 5'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      segs      <= segs_n;
      k         <= k_n;
      pend      <= (state == ISSUE);
      seg_sel   <= sel_n;
      seg_idx   <= idx_n;
      in_ready  <= (state_n == IDLE);
      out_valid <= (state_n == DONE);
      // The table answers one cycle after the request, so the add trails the issue by one.
      if (accept) begin
        acc <= ACC_W'(in_lo);
      end else if (pend) begin
        acc <= acc + ACC_W'(xpb_in);
      end
    end
  end

  assign out_sum = acc;

endmodule

// File: tb/tb_xpb_seq_accum.sv
// Randomized bench for xpb_seq_accum: a cycle-level reference model predicts handshakes,
// table requests and sums; directed cases pin latency, carries, backpressure and reset.
module tb_xpb_seq_accum;

  localparam int NUM_SEG = 8;
  localparam int WORD_W  = 1024;
  localparam int ACC_W   = WORD_W + $clog2(NUM_SEG + 1);
  localparam int HI_W    = NUM_SEG * 5;
  localparam int SEL_W   = 3;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [HI_W-1:0]   in_hi;
  logic [WORD_W-1:0] in_lo;
  logic [SEL_W-1:0]  seg_sel;
  logic [4:0]        seg_idx;
  logic [WORD_W-1:0] xpb_in;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;

  xpb_seq_accum #(.NUM_SEG(NUM_SEG), .WORD_W(WORD_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_hi(in_hi), .in_lo(in_lo), .seg_sel(seg_sel), .seg_idx(seg_idx),
    .xpb_in(xpb_in), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
  );

  int total;
  int bad;
  int cyc;
  bit force_max;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Table bank: xpb(k,i) = (k+1)*2^1000 + i, index 0 reads as zero; optionally all ones.
  function automatic logic [WORD_W-1:0] tbl(input int k, input int i);
    logic [WORD_W-1:0] v;
    if (force_max) v = '1;
    else if (i == 0) v = '0;
    else begin
      v = WORD_W'(k + 1) << 1000;
      v = v + WORD_W'(i);
    end
    return v;
  endfunction

  always @(posedge clk) xpb_in <= tbl(int'(seg_sel), int'(seg_idx));

  task automatic chk(input string nm, input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s at cycle %0d: got top=%h low=%h, want top=%h low=%h",
               nm, cyc, a[ACC_W-1 -: 32], a[63:0], e[ACC_W-1 -: 32], e[63:0]);
    end
  endtask

  task automatic chk_i(input string nm, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", nm, cyc, a, e);
    end
  endtask

  // Reference model state
  typedef struct { int c; int sel; int idx; } iss_t;
  iss_t             iq[$];
  bit               m_busy;
  int               m_due;
  logic [ACC_W-1:0] m_sum;

  // Per-cycle compare against the model, sampled mid-cycle on the falling edge.
  always @(negedge clk) begin : mon
    int n;
    int es;
    int ei;
    bit ev;
    int v;
    if (!rst_n) begin
      m_busy = 1'b0;
      iq.delete();
      chk("rst_in_ready", ACC_W'(in_ready), ACC_W'(1));
      chk("rst_out_valid", ACC_W'(out_valid), ACC_W'(0));
      chk("rst_out_sum", out_sum, '0);
      chk("rst_seg_sel", ACC_W'(seg_sel), ACC_W'(0));
      chk("rst_seg_idx", ACC_W'(seg_idx), ACC_W'(0));
    end else begin
      es = 0;
      ei = 0;
      if (iq.size() > 0 && iq[0].c == cyc) begin
        es = iq[0].sel;
        ei = iq[0].idx;
        void'(iq.pop_front());
      end
      chk("seg_sel", ACC_W'(seg_sel), ACC_W'(es));
      chk("seg_idx", ACC_W'(seg_idx), ACC_W'(ei));
      ev = m_busy && (cyc >= m_due);
      chk("in_ready", ACC_W'(in_ready), ACC_W'(!m_busy));
      chk("out_valid", ACC_W'(out_valid), ACC_W'(ev));
      if (ev) chk("out_sum", out_sum, m_sum);
      if (ev && out_ready) begin
        m_busy = 1'b0;
      end else if (!m_busy && in_valid) begin
        m_sum = ACC_W'(in_lo);
        n = 0;
        for (int k = 0; k < NUM_SEG; k++) begin
          v = int'(in_hi[k*5 +: 5]);
`ifdef XPB_ZERO_SKIP_EN
          if (v == 0) continue;
`endif
          m_sum = m_sum + ACC_W'(tbl(k, v));
          iq.push_back('{cyc + 1 + n, k, v});
          n++;
        end
        m_due  = cyc + n + 2;
        m_busy = 1'b1;
      end
    end
  end

  function automatic logic [WORD_W-1:0] rnd_lo();
    logic [WORD_W-1:0] v;
    for (int i = 0; i < WORD_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [HI_W-1:0] rnd_hi(input bit allow_zero);
    logic [HI_W-1:0] v;
    for (int i = 0; i < NUM_SEG; i++) begin
      if (allow_zero && $urandom_range(1, 0) == 0) v[i*5 +: 5] = 5'd0;
      else v[i*5 +: 5] = 5'($urandom_range(31, 1));
    end
    return v;
  endfunction

  function automatic logic [HI_W-1:0] fill_hi(input int val);
    logic [HI_W-1:0] v;
    for (int i = 0; i < NUM_SEG; i++) v[i*5 +: 5] = 5'(val);
    return v;
  endfunction

  // Offer an operand; c0 is the cycle of the accept handshake.
  task automatic send(input logic [HI_W-1:0] hi, input logic [WORD_W-1:0] lo, output int c0);
    int n;
    n = 0;
    c0 = -1;
    in_hi = hi;
    in_lo = lo;
    in_valid = 1'b1;
    while (c0 < 0 && n < 200) begin
      @(negedge clk);
      n++;
      if (in_ready) c0 = cyc;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (c0 < 0) chk_i("accept_timeout", n, -1);
  endtask

  task automatic wait_valid(output int c1);
    int n;
    n = 0;
    c1 = -1;
    while (c1 < 0 && n < 200) begin
      @(negedge clk);
      n++;
      if (out_valid) c1 = cyc;
    end
    if (c1 < 0) chk_i("valid_timeout", n, -1);
  endtask

  task automatic take(input int stall, input bit junk);
    @(posedge clk);
    #1;
    if (junk) begin
      in_valid = 1'b1;
      in_hi = rnd_hi(1'b1);
      in_lo = rnd_lo();
    end
    repeat (stall) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int c0;
    int c1;
    int prev;
    int n;
    logic [ACC_W-1:0] e;
    logic [ACC_W-1:0] held;
    logic [HI_W-1:0]  hi;
    logic [WORD_W-1:0] lo;
    total = 0; bad = 0; cyc = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_hi = '0; in_lo = '0; out_ready = 1'b0; force_max = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single operand: in_lo=5, every segment 1
    send(fill_hi(1), WORD_W'(5), c0);
    wait_valid(c1);
    chk_i("single_latency", c1 - c0, 10);
    e = (ACC_W'(36) << 1000) + ACC_W'(13);
    chk("single_sum", out_sum, e);
    take(0, 1'b0);

    // Max carry: all-ones low word and table, index 31 everywhere
    force_max = 1'b1;
    send(fill_hi(31), '1, c0);
    wait_valid(c1);
    e = {{(ACC_W-WORD_W){1'b0}}, {WORD_W{1'b1}}};
    e = e * ACC_W'(9);
    chk("maxcarry_sum", out_sum, e);
    chk("maxcarry_top", ACC_W'(out_sum[ACC_W-1:WORD_W]), ACC_W'(8));
    take(0, 1'b0);
    force_max = 1'b0;

    // Backpressure: 20+ stalled cycles in DONE with junk operands offered
    send(rnd_hi(1'b1), rnd_lo(), c0);
    wait_valid(c1);
    held = out_sum;
    take(20, 1'b1);
    chk("stall_sum_held", out_sum, held);
    @(negedge clk);
    chk("release_in_ready", ACC_W'(in_ready), ACC_W'(1));
    @(posedge clk);
    #1;

    // Reset while k=4 is being issued
    send(fill_hi(1), rnd_lo(), c0);
    n = 0;
    while (seg_sel != 3'd4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk_i("reach_k4", int'(seg_sel), 4);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send('0, WORD_W'(7), c0);
    wait_valid(c1);
    chk("post_reset_sum", out_sum, ACC_W'(7));
    take(0, 1'b0);

    // Sparse segments {0,3,0,0,9,0,0,0}
    hi = '0;
    hi[1*5 +: 5] = 5'd3;
    hi[4*5 +: 5] = 5'd9;
    send(hi, WORD_W'(100), c0);
    wait_valid(c1);
`ifdef XPB_ZERO_SKIP_EN
    chk_i("sparse_latency", c1 - c0, 4);
`else
    chk_i("sparse_latency", c1 - c0, 10);
`endif
    e = (ACC_W'(7) << 1000) + ACC_W'(112);
    chk("sparse_sum", out_sum, e);
    take(1, 1'b0);

    // All-zero segments
    lo = rnd_lo();
    send('0, lo, c0);
    wait_valid(c1);
`ifdef XPB_ZERO_SKIP_EN
    chk_i("zero_latency", c1 - c0, 2);
`else
    chk_i("zero_latency", c1 - c0, 10);
`endif
    chk("zero_sum", out_sum, ACC_W'(lo));
    take(0, 1'b0);

    // Randomized operands with random stalls and junk offers
    for (int t = 0; t < 30; t++) begin
      send(rnd_hi(1'b1), rnd_lo(), c0);
      wait_valid(c1);
      take($urandom_range(4, 0), 1'($urandom_range(1, 0)));
    end

    // Streaming with out_ready held high: one operand per NUM_SEG+3 cycles
    out_ready = 1'b1;
    prev = -1;
    for (int t = 0; t < 5; t++) begin
      send(rnd_hi(1'b0), rnd_lo(), c0);
      if (prev >= 0) chk_i("throughput", c0 - prev, 11);
      prev = c0;
    end
    wait_valid(c1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xpb_seq_accum.md
# xpb_seq_accum

Sequential reduction accumulator that feeds the 5-bit xpb lookup tables and sums what they return. It walks the upper bits of a wide operand one 5-bit segment per cycle and drives table select and index to the table bank, whose output is registered with 1-cycle latency. It adds each returned 1024-bit value onto the operand's low word and hands the unreduced sum downstream over a valid/ready handshake.

## Interface
- `NUM_SEG`, default 8: number of 5-bit segments in `in_hi`; legal range 1–32.
- `WORD_W`, default 1024: width of `in_lo` and of each `xpb_in` term.
- `ACC_W`, default `WORD_W + $clog2(NUM_SEG+1)`: width of the accumulator and `out_sum`; the block does not override it.
- `clk`, input, 1: single clock; all state on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: an operand is offered.
- `in_ready`, output, 1: the block accepts an operand; high only in IDLE.
- `in_hi`, input, `NUM_SEG*5`: upper bits; segment k is `in_hi[5k+4:5k]`.
- `in_lo`, input, `WORD_W`: low word; this is the accumulator seed.
- `seg_sel`, output, `$clog2(NUM_SEG)` (min 1): selects which xpb table is read.
- `seg_idx`, output, 5: index presented to the selected table.
- `xpb_in`, input, `WORD_W`: registered table output, valid 1 cycle after `seg_sel`/`seg_idx`.
- `out_valid`, output, 1: `out_sum` is complete.
- `out_ready`, input, 1: the consumer takes `out_sum`.
- `out_sum`, output, `ACC_W`: `in_lo` + Σ xpb(k, seg_k).

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: latch `in_hi` into the segment register, load acc ← zero-extended `in_lo`, clear k, go to ISSUE.
- ISSUE:
  - Each cycle drives `seg_sel`=k and `seg_idx`=seg_k, sets the issue-pending flag, and increments k.
  - After issuing k=NUM_SEG-1, go to DRAIN.
- Pending flag: when it is set in cycle t, cycle t+1 performs acc ← acc + zero-extended `xpb_in`.
- DRAIN: one cycle; the final pending add completes, then go to DONE.
- DONE:
  - `out_valid`=1 and `out_sum`=acc, held stable until `out_ready`.
  - On `out_ready`, go to IDLE; `in_ready` rises the next cycle. Accept and output never overlap.
- Arithmetic:
  - Unsigned addition with no reduction.
  - `ACC_W` guarantees no overflow: the sum is < (NUM_SEG+1)·2^WORD_W.
- Outside ISSUE, `seg_sel`/`seg_idx` hold 0. Index 0 returns 0 by table definition, so idle reads are harmless.
- `in_valid` while not IDLE is ignored, and its operand is not captured.
- Reset (asynchronous, any state, including mid-ISSUE):
  - Clears state to IDLE, acc, k, and the pending flag.
  - `out_valid`=0, `in_ready`=1 immediately after reset deasserts.
  - An in-flight `xpb_in` after reset is discarded.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_sum`=0, `seg_sel`=0, `seg_idx`=0.
- The accept handshake is cycle 0; ISSUE occupies cycles 1..NUM_SEG, DRAIN is cycle NUM_SEG+1, and `out_valid` rises in cycle NUM_SEG+2.
- Latency from accept to `out_valid` is NUM_SEG+2 cycles; the default is 10.
- Throughput is one operand per NUM_SEG+3 cycles when `out_ready` is held high.
- NUM_SEG=1: ISSUE lasts 1 cycle and latency is 3.
- `out_ready` low stalls indefinitely in DONE; `out_sum` does not change.

## Configuration
- `XPB_ZERO_SKIP_EN` defined:
  - ISSUE scans from the current k to the next segment with non-zero index and issues only that segment. Each non-zero segment still takes one cycle; zero segments take no cycles.
  - Latency becomes Z+2, where Z is the count of non-zero segments.
  - If all segments are zero, go from IDLE directly to DRAIN, so `out_valid` rises 2 cycles after accept with `out_sum`=`in_lo`.
- Macro undefined: fixed NUM_SEG+2 latency; all segments are issued regardless of value.

## Test plan
- Bench table model: xpb(k,i) = (k+1)·2^1000 + i. Run with NUM_SEG=8.
- Single op: `in_lo`=5, all segments=1 → `out_sum` = 5 + 36·2^1000 + 8; `out_valid` exactly 10 cycles after accept.
- Max carry: `in_lo`=2^1024−1, table forced to 2^1024−1 for all k, all idx=31 → `out_sum`=9·(2^1024−1); bits [1027:1024]=8, no truncation.
- Backpressure: hold `out_ready`=0 for 20 cycles in DONE → `out_sum` stable and `in_ready`=0 throughout; on release, IDLE next cycle. `in_valid` during the stall is not captured.
- Reset mid-ISSUE: assert `rst_n`=0 when k=4 → outputs at reset values. The next operand `in_lo`=7 with all-zero segments gives `out_sum`=7 with no residue.
- Zero-skip (macro on): segments {0,3,0,0,9,0,0,0} → only seg_sel 1 and 4 are issued; `out_valid` 4 cycles after accept. All-zero segments give `out_valid` in 2 cycles. With the macro off, both cases take 10 cycles and give identical sums.
